// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: the response encoding used on the B and R channels.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } response_t;

endpackage

// File: rtl/bch_regs_pkg.sv
// Register map of the BCH control/status bank: offsets, field positions and decode helper.
package bch_regs_pkg;

  typedef logic [7:0] word_idx_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  localparam logic [9:0] REG_CTRL_OFF   = 10'h000;
  localparam logic [9:0] REG_STATUS_OFF = 10'h004;
  localparam logic [9:0] REG_DIN_OFF    = 10'h008;
  localparam logic [9:0] REG_DOUT_OFF   = 10'h00C;
  localparam logic [9:0] REG_ERRCNT_OFF = 10'h010;

  localparam word_idx_t IDX_CTRL   = REG_CTRL_OFF[9:2];
  localparam word_idx_t IDX_STATUS = REG_STATUS_OFF[9:2];
  localparam word_idx_t IDX_DIN    = REG_DIN_OFF[9:2];
  localparam word_idx_t IDX_DOUT   = REG_DOUT_OFF[9:2];
  localparam word_idx_t IDX_ERRCNT = REG_ERRCNT_OFF[9:2];

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_MODE_BIT   = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  // The map is dense from CTRL up to ERRCNT.
  function automatic logic is_mapped(input word_idx_t idx);
    return idx <= IDX_ERRCNT;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
interface axi4_lite_if #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 5
) ();
  import axi4_lite_pkg::*;

  logic                     awvalid;
  logic                     awready;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic                     wvalid;
  logic                     wready;
  logic [DATA_BYTES*8-1:0]  wdata;
  logic [DATA_BYTES-1:0]    wstrb;
  logic                     bvalid;
  logic                     bready;
  response_t                bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic                     rvalid;
  logic                     rready;
  logic [DATA_BYTES*8-1:0]  rdata;
  response_t                rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/bch_axil_regs.sv
// AXI4-Lite register bank for the BCH core: independent AW/W holding registers merge
// into one write commit; a two-state FSM serves reads.
module bch_axil_regs
  import axi4_lite_pkg::*;
  import bch_regs_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic        aclk,
  input  logic        areset,
  axi4_lite_if.slave  s_axi,
  output logic        core_start,
  output logic        core_mode,
  output logic [31:0] core_din,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic [31:0] core_dout,
  input  logic [7:0]  core_errcnt
);

  localparam int DW = DATA_BYTES * 8;

  logic                  aw_full_q, aw_full_d;
  word_idx_t             aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DW-1:0]         w_data_q, w_data_d;
  logic [DATA_BYTES-1:0] w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  response_t             bresp_q, bresp_d;

  logic                  mode_q, mode_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic [31:0]           din_q, din_d;
  logic [31:0]           dout_q, dout_d;
  logic [7:0]            errcnt_q, errcnt_d;

  r_state_t              r_state_q, r_state_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  response_t             rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, wr_commit;
  word_idx_t             wr_idx, rd_idx;
  logic [DW-1:0]         wr_data, rd_value;
  logic [DATA_BYTES-1:0] wr_strb;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Readies depend only on state so a master can never see them combinationally echo valid.
  assign s_axi.awready = !areset && !aw_full_q && !bvalid_q;
  assign s_axi.wready  = !areset && !w_full_q && !bvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign core_start = start_q;
  assign core_mode  = mode_q;
  assign core_din   = din_q;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;

  // A held beat takes priority; otherwise the beat handshaking this cycle is used directly.
  assign wr_idx    = aw_full_q ? aw_idx_q : word_idx_t'(s_axi.awaddr[ADDRESS_WIDTH-1:2]);
  assign wr_data   = w_full_q ? w_data_q : s_axi.wdata;
  assign wr_strb   = w_full_q ? w_strb_q : s_axi.wstrb;
  assign wr_commit = (aw_full_q || aw_hs) && (w_full_q || w_hs);

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mode_d    = mode_q;
    start_d   = 1'b0;
    done_d    = done_q;
    din_d     = din_q;
    dout_d    = dout_q;
    errcnt_d  = errcnt_q;

    if (core_done) begin
      dout_d   = core_dout;
      errcnt_d = core_errcnt;
      done_d   = 1'b1;
    end

    if (bvalid_q && s_axi.bready) begin
      bvalid_d = 1'b0;
    end

    if (aw_hs && !wr_commit) begin
      aw_full_d = 1'b1;
      aw_idx_d  = word_idx_t'(s_axi.awaddr[ADDRESS_WIDTH-1:2]);
    end
    if (w_hs && !wr_commit) begin
      w_full_d = 1'b1;
      w_data_d = s_axi.wdata;
      w_strb_d = s_axi.wstrb;
    end

    if (wr_commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = OKAY;
      if (!is_mapped(wr_idx)) begin
        bresp_d = SLVERR;
      end else begin
        case (wr_idx)
          IDX_CTRL: begin
            if (wr_strb[0]) begin
              mode_d = wr_data[CTRL_MODE_BIT];
              if (wr_data[CTRL_START_BIT]) begin
                if (core_busy) bresp_d = SLVERR;
                else           start_d = 1'b1;
              end
            end
          end
          IDX_STATUS: begin
            // A completion in the same cycle wins over the clear.
            if (wr_strb[0] && wr_data[STATUS_DONE_BIT] && !core_done) done_d = 1'b0;
          end
          IDX_DIN: begin
            for (int b = 0; b < DATA_BYTES; b++) begin
              if (wr_strb[b]) din_d[8*b +: 8] = wr_data[8*b +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      mode_q    <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      din_q     <= '0;
      dout_q    <= '0;
      errcnt_q  <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      mode_q    <= mode_d;
      start_q   <= start_d;
      done_q    <= done_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      errcnt_q  <= errcnt_d;
    end
  end

  // Read value is taken from current state, so a same-cycle write is not visible yet.
  assign rd_idx = word_idx_t'(s_axi.araddr[ADDRESS_WIDTH-1:2]);

  always_comb begin
    rd_value = '0;
    case (rd_idx)
      IDX_CTRL:   rd_value[CTRL_MODE_BIT] = mode_q;
      IDX_STATUS: begin
        rd_value[STATUS_BUSY_BIT] = core_busy;
        rd_value[STATUS_DONE_BIT] = done_q;
      end
      IDX_DIN:    rd_value = din_q;
      IDX_DOUT:   rd_value = dout_q;
      IDX_ERRCNT: rd_value[7:0] = errcnt_q;
      default:    rd_value = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (s_axi.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = !areset && (r_state_q == R_IDLE);
    s_axi.rvalid  = (r_state_q == R_RESP);
  end

  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rdata_d = rd_value;
      rresp_d = is_mapped(rd_idx) ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

endmodule

// File: tb/tb_bch_axil_regs.sv
// Directed bench for bch_axil_regs with a transaction-level register model.
module tb_bch_axil_regs;

  logic        clk = 1'b0;
  logic        areset;
  logic        core_start;
  logic        core_mode;
  logic [31:0] core_din;
  logic        core_busy;
  logic        core_done;
  logic [31:0] core_dout;
  logic [7:0]  core_errcnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic done_at_edge = 1'b0;

  // Register model
  logic        m_mode;
  logic        m_done;
  logic [31:0] m_din;
  logic [31:0] m_dout;
  logic [7:0]  m_errcnt;
  int          m_start_cycle;

  axi4_lite_if #(.DATA_BYTES(4), .ADDRESS_WIDTH(5)) axi();

  bch_axil_regs #(.DATA_BYTES(4), .ADDRESS_WIDTH(5)) dut (
    .aclk        (clk),
    .areset      (areset),
    .s_axi       (axi),
    .core_start  (core_start),
    .core_mode   (core_mode),
    .core_din    (core_din),
    .core_busy   (core_busy),
    .core_done   (core_done),
    .core_dout   (core_dout),
    .core_errcnt (core_errcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) done_at_edge <= core_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_mode = 1'b0; m_done = 1'b0; m_din = '0; m_dout = '0; m_errcnt = '0;
    m_start_cycle = -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    case (addr[4:2])
      3'd0:    return {30'd0, m_mode, 1'b0};
      3'd1:    return {30'd0, m_done, core_busy};
      3'd2:    return m_din;
      3'd3:    return m_dout;
      3'd4:    return {24'd0, m_errcnt};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] model_write(input logic [4:0] addr, input logic [31:0] d,
                                             input logic [3:0] s);
    int idx = int'(addr[4:2]);
    if (idx > 4) return 2'b10;
    if (idx == 0 && s[0]) begin
      m_mode = d[1];
      if (d[0]) begin
        if (core_busy) return 2'b10;
        m_start_cycle = cyc;
      end
    end
    if (idx == 1 && s[0] && d[1] && !done_at_edge) m_done = 1'b0;
    if (idx == 2) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_din[8*b +: 8] = d[8*b +: 8];
    end
    return 2'b00;
  endfunction

  // Per-cycle comparison of the core-facing outputs against the model
  always @(negedge clk) begin
    if (!areset) begin
      check("core_mode", 32'(core_mode), 32'(m_mode));
      check("core_din", core_din, m_din);
      check("core_start", 32'(core_start), 32'(cyc == m_start_cycle));
    end
  end

  task automatic do_reset(input int n);
    areset = 1'b1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    axi.bready = 1'b0; axi.rready = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check("reset_readies", {29'd0, axi.awready, axi.wready, axi.arready}, 32'd0);
    end
    model_reset();
    areset = 1'b0;
    #1;
  endtask

  task automatic axi_write(input string name, input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_hold, input bit abandon, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int c = 0;
    logic [1:0] exp_resp;
    resp = 2'bxx;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
    while (!(aw_done && w_done)) begin
      axi.awvalid = !aw_done && (c >= aw_dly);
      axi.wvalid  = !w_done && (c >= w_dly);
      aw_fire = axi.awvalid && axi.awready;
      w_fire  = axi.wvalid && axi.wready;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      c++;
      if (!(aw_done && w_done)) check({name, "_bvalid_early"}, 32'(axi.bvalid), 32'd0);
      if (c > 40) begin
        check({name, "_handshake_timeout"}, 32'(c), 32'd0);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        return;
      end
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    exp_resp = model_write(addr, data, strb);
    check({name, "_bvalid"}, 32'(axi.bvalid), 32'd1);
    check({name, "_bresp"}, 32'(axi.bresp), 32'(exp_resp));
    resp = axi.bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      check({name, "_bvalid_hold"}, 32'(axi.bvalid), 32'd1);
      check({name, "_bresp_hold"}, 32'(axi.bresp), 32'(exp_resp));
      check({name, "_ready_hold"}, {30'd0, axi.awready, axi.wready}, 32'd0);
    end
    if (abandon) return;
    axi.bready = 1'b1;
    @(posedge clk); #1;
    axi.bready = 1'b0;
    check({name, "_bvalid_clr"}, 32'(axi.bvalid), 32'd0);
  endtask

  task automatic axi_read(input string name, input logic [4:0] addr, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    bit fire;
    int c = 0;
    data = 'x; resp = 'x;
    exp_r = (addr[4:2] > 3'd4) ? 2'b10 : 2'b00;
    axi.araddr = addr;
    axi.arvalid = 1'b1;
    do begin
      fire  = axi.arready;
      exp_d = model_read(addr);
      @(posedge clk); #1;
      c++;
      if (c > 40) begin
        check({name, "_ar_timeout"}, 32'(c), 32'd0);
        axi.arvalid = 1'b0;
        return;
      end
    end while (!fire);
    axi.arvalid = 1'b0;
    check({name, "_rvalid"}, 32'(axi.rvalid), 32'd1);
    check({name, "_rdata"}, axi.rdata, exp_d);
    check({name, "_rresp"}, 32'(axi.rresp), 32'(exp_r));
    data = axi.rdata; resp = axi.rresp;
    for (int i = 0; i < r_hold; i++) begin
      @(posedge clk); #1;
      check({name, "_rvalid_hold"}, 32'(axi.rvalid), 32'd1);
      check({name, "_rdata_hold"}, axi.rdata, exp_d);
      check({name, "_arready_hold"}, 32'(axi.arready), 32'd0);
    end
    axi.rready = 1'b1;
    @(posedge clk); #1;
    axi.rready = 1'b0;
    check({name, "_rvalid_clr"}, 32'(axi.rvalid), 32'd0);
  endtask

  task automatic pulse_done(input logic [31:0] dout, input logic [7:0] ec);
    core_done = 1'b1; core_dout = dout; core_errcnt = ec;
    @(posedge clk); #1;
    m_done = 1'b1; m_dout = dout; m_errcnt = ec;
    core_done = 1'b0; core_dout = $urandom; core_errcnt = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] d2;
    logic [1:0]  r2;
    model_reset();
    areset = 1'b1;
    core_busy = 1'b0; core_done = 1'b0; core_dout = '0; core_errcnt = '0;
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
    axi.bready = 1'b0; axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b0;
    do_reset(3);
    check("readies_after_reset", {29'd0, axi.awready, axi.wready, axi.arready}, 32'd7);
    check("bvalid_after_reset", {30'd0, axi.bvalid, axi.rvalid}, 32'd0);

    axi_read("rd_status0", 5'h04, 0, d, r);
    check("lit_status0", d, 32'h0);
    check("lit_status0_resp", 32'(r), 32'd0);

    axi_write("wr_din_aw_first", 5'h08, 32'h12345678, 4'b0011, 0, 3, 0, 0, r);
    check("lit_din_aw_first_resp", 32'(r), 32'd0);
    axi_read("rd_din1", 5'h08, 2, d, r);
    check("lit_din1", d, 32'h00005678);

    axi_write("wr_din_w_first", 5'h08, 32'hA5A5A5A5, 4'b1100, 2, 0, 0, 0, r);
    axi_read("rd_din2", 5'h08, 0, d, r);
    check("lit_din2", d, 32'hA5A55678);

    axi_write("wr_ctrl_start", 5'h00, 32'h3, 4'hF, 0, 0, 0, 0, r);
    check("lit_ctrl_start_resp", 32'(r), 32'd0);
    axi_read("rd_ctrl", 5'h00, 0, d, r);
    check("lit_ctrl", d, 32'h2);

    core_busy = 1'b1;
    axi_write("wr_ctrl_busy", 5'h00, 32'h3, 4'hF, 0, 0, 0, 0, r);
    check("lit_ctrl_busy_resp", 32'(r), 32'd2);
    axi_read("rd_status_busy", 5'h04, 0, d, r);
    check("lit_status_busy", d, 32'h1);
    core_busy = 1'b0;
    axi_write("wr_ctrl_mode0", 5'h00, 32'h0, 4'hF, 0, 0, 0, 0, r);

    pulse_done(32'hDEADBEEF, 8'd3);
    axi_read("rd_dout", 5'h0C, 0, d, r);
    check("lit_dout", d, 32'hDEADBEEF);
    axi_read("rd_errcnt", 5'h10, 0, d, r);
    check("lit_errcnt", d, 32'h3);
    axi_read("rd_status_done", 5'h04, 0, d, r);
    check("lit_status_done", d, 32'h2);
    axi_write("wr_dout_ro", 5'h0C, 32'h0, 4'hF, 0, 0, 0, 0, r);
    check("lit_dout_ro_resp", 32'(r), 32'd0);
    axi_write("wr_status_clr", 5'h04, 32'h2, 4'h1, 0, 0, 0, 0, r);
    axi_read("rd_status_clr", 5'h04, 0, d, r);
    check("lit_status_clr", d, 32'h0);

    fork
      axi_write("wr_status_collide", 5'h04, 32'h2, 4'h1, 0, 0, 0, 0, r);
      pulse_done(32'h0000CAFE, 8'd7);
    join
    axi_read("rd_status_collide", 5'h04, 0, d, r);
    check("lit_status_collide", d, 32'h2);

    axi_read("rd_unmapped", 5'h14, 0, d, r);
    check("lit_unmapped_data", d, 32'h0);
    check("lit_unmapped_resp", 32'(r), 32'd2);
    axi_write("wr_unmapped", 5'h1C, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 0, r);
    check("lit_wr_unmapped_resp", 32'(r), 32'd2);
    axi_read("rd_din_after_unmapped", 5'h08, 0, d, r);
    check("lit_din_after_unmapped", d, 32'hA5A55678);

    fork
      axi_write("wr_din_collide", 5'h08, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, r);
      axi_read("rd_din_collide", 5'h08, 0, d2, r2);
    join
    check("lit_din_collide_old", d2, 32'hA5A55678);
    axi_read("rd_din_new", 5'h08, 0, d, r);
    check("lit_din_new", d, 32'h0BADF00D);

    axi_write("wr_bhold", 5'h00, 32'h2, 4'hF, 0, 0, 5, 1, r);
    areset = 1'b1;
    @(posedge clk); #1;
    check("bvalid_after_mid_reset", 32'(axi.bvalid), 32'd0);
    do_reset(1);
    axi_read("rd_din_post_reset", 5'h08, 0, d, r);
    check("lit_din_post_reset", d, 32'h0);
    axi_read("rd_ctrl_post_reset", 5'h00, 0, d, r);
    check("lit_ctrl_post_reset", d, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bch_axil_regs.md
# bch_axil_regs

AXI4-Lite slave that terminates an `axi4_lite_if.slave` port and exposes the BCH encoder/decoder control/status register bank. It sits between the system interconnect and the BCH core. It converts bus writes into a start pulse, a mode bit and an input word. It returns core results, busy/done status and error count on reads.

## Interface
- `DATA_BYTES`, 4: bus data width in bytes; only 4 is supported.
- `ADDRESS_WIDTH`, 5: byte address width of the `awaddr`/`araddr` fields.
- `aclk`  input  1  clock, rising edge.
- `areset`  input  1  reset. Synchronous, active-high; the single clock is `aclk`.
- `s_axi`  interface  `axi4_lite_if.slave` (DATA_BYTES, ADDRESS_WIDTH)  bus port.
- `core_start`  output  1  one-cycle start pulse to the core.
- `core_mode`  output  1  0 = encode, 1 = decode.
- `core_din`  output  32  input word to the core.
- `core_busy`  input  1  the core is processing.
- `core_done`  input  1  one-cycle completion pulse.
- `core_dout`  input  32  result word; valid in the `core_done` cycle.
- `core_errcnt`  input  8  corrected-error count; valid in the `core_done` cycle.

## Operation
Register map. Word index is `addr[ADDRESS_WIDTH-1:2]`; `addr[1:0]` is ignored.
- 0x00 CTRL (RW)
  - bit0 START: write 1 pulses `core_start`; reads as 0.
  - bit1 MODE: stored; drives `core_mode`.
- 0x04 STATUS
  - bit0 BUSY (RO): mirrors `core_busy`.
  - bit1 DONE (W1C): sticky; set by `core_done`.
- 0x08 DIN (RW): drives `core_din`.
- 0x0C DOUT (RO): captured from `core_dout` on `core_done`.
- 0x10 ERRCNT (RO): bits[7:0] captured from `core_errcnt` on `core_done`; upper bits read 0.
- Other word indices: unmapped. Reads return 0 with SLVERR; writes are discarded with SLVERR.
- Writes to RO fields are ignored and respond OKAY.
- `wstrb` gates writes per byte on RW fields and on the DONE W1C bit.

Write path. The address and data channels are independent; each has a one-entry holding register.
- `awready` = AW holding register empty and `bvalid` low.
- `wready` = W holding register empty and `bvalid` low.
- The write commits on the first edge at which both holding registers are full, or at which both handshakes occur together.
- START=1 while `core_busy`=1: no pulse, MODE is still updated, response is SLVERR.

Read path. FSM with states R_IDLE and R_RESP.
- `arready` is high only in R_IDLE.
- The handshake latches `rdata`/`rresp` and moves to R_RESP.
- `rvalid && rready` returns the FSM to R_IDLE.

Collisions:
- `core_done` and a W1C clear of DONE in the same cycle: DONE stays set.
- A read and a write to the same register in the same cycle: the read returns the pre-write value.

## Timing
- During `areset`, all registers clear: CTRL, DIN, DOUT, ERRCNT, DONE = 0; `bvalid`, `rvalid`, `core_start` = 0; `rdata` = 0; `bresp`, `rresp` = OKAY. All ready outputs are forced 0.
- Ready outputs are combinational from state, so they rise in the first cycle after `areset` falls.
- Write latency: if AW and W handshake at edge N, the register updates and `bvalid` rises at edge N. `core_start` is high for the single cycle after edge N.
- `bvalid`/`bresp` hold until `bready`. No new AW or W is accepted while `bvalid` is high.
- Read latency: AR handshake at edge N, then `rvalid`/`rdata`/`rresp` valid after edge N. They hold stable until `rready`.
- Maximum read throughput is one read per 2 cycles.
- Reset asserted mid-transaction drops any pending response and clears the holding registers; no handshake completes afterwards.

## Structure
- `axi4_lite_pkg` provides `response_t` (OKAY, SLVERR).
- New `bch_regs_pkg` holds:
  - register offset localparams;
  - CTRL/STATUS bit positions;
  - an `is_mapped(word_index)` function.
- No sub-module; the write merge and read FSM live in one module.

## Test plan
- Reset, then read 0x04 with `core_busy`=0 → `rdata`=0x0, OKAY, `rvalid` one cycle after AR.
- AW only at cycle 0, W (0x12345678, `wstrb`=4'b0011) at cycle 3, `bready`=1 → DIN=0x00005678, `bvalid` after cycle 3, OKAY.
- Write CTRL=0x3 with `core_busy`=0 → `core_start` high exactly 1 cycle, `core_mode`=1. Repeat with `core_busy`=1 → no pulse, SLVERR.
- `core_done` with `core_dout`=0xDEADBEEF, `core_errcnt`=3 → DOUT reads 0xDEADBEEF, ERRCNT reads 0x3, STATUS reads 0x2. Write 0x2 to STATUS → STATUS reads 0x0. Repeat with `core_done` in the same cycle as the clear → STATUS reads 0x2.
- Read 0x14 → `rdata`=0, SLVERR. Write 0x1C → SLVERR and no register changes.
- Hold `bready`=0 for 5 cycles → `awready`/`wready` low and `bvalid`/`bresp` stable throughout. Assert `areset` mid-wait → `bvalid`=0 on the next cycle.
